vpu_alu_simd: RTL and testbench

- Next-generation vector integer ALU for the VPU execute stage: packed SIMD, processing every element of a DATA_W-bit beat (DATA_W/SEW lanes) per cycle.
- Adds a valid/ready handshake, a configurable-latency stall-able pipeline, per-lane masking with byte enables, packed compare-mask results, and a sticky saturation flag.
- Sits between the operand-read stage and the VRF write-back arbiter.

---
 rtl/vpu_alu_simd.sv | 253 +++++++++++++++++++++++++
 tb/tb_vpu_alu_simd.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_alu_simd.sv
// vpu_alu_simd: packed-SIMD vector integer ALU for the VPU execute stage.
// Element width is selected per beat (8/16/32/64). Results flow through a
// LATENCY-deep stall-able pipeline with per-element masking and byte enables.
// Optional feature macro: VPU_ALU_VXSAT_EN enables the saturating SADD/SSUB
// clamp and the sticky vxsat flag; without it SADD/SSUB wrap like ADD/SUB.
module vpu_alu_simd #(
  parameter int DATA_W  = 64,
  parameter int LATENCY = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [3:0]          op_i,
  input  logic                signed_i,
  input  logic [1:0]          sew_i,
  input  logic [DATA_W-1:0]   op1_i,
  input  logic [DATA_W-1:0]   op2_i,
  input  logic [DATA_W/8-1:0] mask_i,
  input  logic                flush_i,
  input  logic                vxsat_clr_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [DATA_W-1:0]   result_o,
  output logic [DATA_W/8-1:0] be_o,
  output logic                vxsat_o
);

  localparam int NB = DATA_W / 8;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_RSUB = 4'd2,  OP_AND  = 4'd3,
    OP_OR   = 4'd4,  OP_XOR  = 4'd5,  OP_SLL  = 4'd6,  OP_SRL  = 4'd7,
    OP_SRA  = 4'd8,  OP_MIN  = 4'd9,  OP_MAX  = 4'd10, OP_MSEQ = 4'd11,
    OP_MSNE = 4'd12, OP_MSLT = 4'd13, OP_SADD = 4'd14, OP_SSUB = 4'd15
  } op_e;

  typedef struct packed {
    logic [63:0] res;
    logic        cmp;
`ifdef VPU_ALU_VXSAT_EN
    logic        sat;
`endif
  } lane_t;

  // One element of any width, computed in a 64-bit container; a = op1, b = op2.
  function automatic lane_t lane_op(input op_e op, input logic sgn, input logic [1:0] sew,
                                    input logic [63:0] a, input logic [63:0] b);
    lane_t       r;
    logic [6:0]  w;
    logic [5:0]  sb;
    logic [5:0]  sh;
    logic [63:0] msk, am, bm, sxa, sxb;
    logic        lt;
`ifdef VPU_ALU_VXSAT_EN
    logic [64:0] s;
    logic [63:0] d, hmax, hmin;
`endif
    w   = 7'd8 << sew;
    sb  = 6'(w - 7'd1);
    msk = (sew == 2'd3) ? '1 : ((64'd1 << w) - 64'd1);
    am  = a & msk;
    bm  = b & msk;
    sxa = am[sb] ? (am | ~msk) : am;
    sxb = bm[sb] ? (bm | ~msk) : bm;
    sh  = 6'(am) & sb;
    // op2 < op1 drives MIN/MAX/MSLT
    lt  = sgn ? ($signed(sxb) < $signed(sxa)) : (bm < am);
    r   = '0;
`ifdef VPU_ALU_VXSAT_EN
    s    = {1'b0, bm} + {1'b0, am};
    d    = bm - am;
    hmax = msk >> 1;
    hmin = msk & ~hmax;
`endif
    case (op)
      OP_ADD:  r.res = bm + am;
      OP_SUB:  r.res = bm - am;
      OP_RSUB: r.res = am - bm;
      OP_AND:  r.res = bm & am;
      OP_OR:   r.res = bm | am;
      OP_XOR:  r.res = bm ^ am;
      OP_SLL:  r.res = bm << sh;
      OP_SRL:  r.res = bm >> sh;
      OP_SRA:  r.res = $unsigned($signed(sxb) >>> sh);
      OP_MIN:  r.res = lt ? bm : am;
      OP_MAX:  r.res = lt ? am : bm;
      OP_MSEQ: r.cmp = (am == bm);
      OP_MSNE: r.cmp = (am != bm);
      OP_MSLT: r.cmp = lt;
`ifdef VPU_ALU_VXSAT_EN
      OP_SADD: begin
        r.res = s[63:0];
        if (!sgn && s[w]) begin
          r.res = msk;
          r.sat = 1'b1;
        end else if (sgn && (am[sb] == bm[sb]) && (s[{1'b0, sb}] != bm[sb])) begin
          r.res = bm[sb] ? hmin : hmax;
          r.sat = 1'b1;
        end
      end
      OP_SSUB: begin
        r.res = d;
        if (!sgn && (bm < am)) begin
          r.res = '0;
          r.sat = 1'b1;
        end else if (sgn && (am[sb] != bm[sb]) && (d[sb] != bm[sb])) begin
          r.res = bm[sb] ? hmin : hmax;
          r.sat = 1'b1;
        end
      end
`else
      OP_SADD: r.res = bm + am;
      OP_SSUB: r.res = bm - am;
`endif
    endcase
    r.res = r.res & msk;
    return r;
  endfunction

  logic              advance, accept;
  logic [DATA_W-1:0] beat_res;
  logic [NB-1:0]     beat_be;
`ifdef VPU_ALU_VXSAT_EN
  logic              beat_sat;
`endif

  assign advance     = out_ready_i | ~out_valid_o;
  assign in_ready_o  = advance & ~flush_i;
  assign accept      = in_valid_i & in_ready_o;

  // Evaluate every element of the incoming beat and build result/byte enables.
  always_comb begin
    int          w, n;
    logic [63:0] ea, eb;
    lane_t       l;
    logic [NB-1:0] msh;
    logic        is_cmp;
    // NOTE: every variable gets a value before any branch, so no latch can be inferred.
    beat_res = '0;
    beat_be  = '0;
`ifdef VPU_ALU_VXSAT_EN
    beat_sat = 1'b0;
`endif
    ea     = '0;
    eb     = '0;
    l      = '0;
    msh    = '0;
    w      = 8 << sew_i;
    n      = DATA_W / w;
    is_cmp = op_i inside {OP_MSEQ, OP_MSNE, OP_MSLT};
    for (int k = 0; k < NB; k++) begin
      if (k < n) begin
        ea = 64'(op1_i >> (k * w));
        eb = 64'(op2_i >> (k * w));
        l  = lane_op(op_e'(op_i), signed_i, sew_i, ea, eb);
        if (mask_i[k]) begin
          if (is_cmp) beat_res[k] = l.cmp;
          else        beat_res    = beat_res | (DATA_W'(l.res) << (k * w));
`ifdef VPU_ALU_VXSAT_EN
          beat_sat = beat_sat | l.sat;
`endif
        end
      end
    end
    for (int j = 0; j < NB; j++) begin
      msh        = mask_i >> (j / (w / 8));
      beat_be[j] = is_cmp | msh[0];
    end
  end

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [DATA_W-1:0]  res_q [LATENCY];
  logic [DATA_W-1:0]  res_d [LATENCY];
  logic [NB-1:0]      be_q  [LATENCY];
  logic [NB-1:0]      be_d  [LATENCY];

  // Pipeline next state: shift on advance, hold on stall, flush kills valids.
  always_comb begin
    valid_d = valid_q;
    res_d   = res_q;
    be_d    = be_q;
    if (advance) begin
      valid_d[0] = accept;
      if (accept) begin
        res_d[0] = beat_res;
        be_d[0]  = beat_be;
      end
      for (int i = 1; i < LATENCY; i++) begin
        valid_d[i] = valid_q[i-1];
        res_d[i]   = res_q[i-1];
        be_d[i]    = be_q[i-1];
      end
    end
    if (flush_i) valid_d = '0;
  end

  // Pipeline registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      // NOTE: data stages are reset too because result_o/be_o must read 0 out of reset.
      for (int i = 0; i < LATENCY; i++) begin
        res_q[i] <= '0;
        be_q[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every stage samples pre-edge values.
      valid_q <= valid_d;
      res_q   <= res_d;
      be_q    <= be_d;
    end
  end

  assign out_valid_o = valid_q[LATENCY-1];
  assign result_o    = res_q[LATENCY-1];
  assign be_o        = be_q[LATENCY-1];

`ifdef VPU_ALU_VXSAT_EN
  logic [LATENCY-1:0] sat_q, sat_d;
  logic               vxsat_q, vxsat_d;

  // Per-beat saturation flag travels with the beat; vxsat is set on completion.
  always_comb begin
    sat_d = sat_q;
    if (advance) begin
      if (accept) sat_d[0] = beat_sat;
      for (int i = 1; i < LATENCY; i++) sat_d[i] = sat_q[i-1];
    end
    vxsat_d = vxsat_q;
    if (vxsat_clr_i) vxsat_d = 1'b0;
    if (out_valid_o && out_ready_i && sat_q[LATENCY-1]) vxsat_d = 1'b1;
  end

  // Saturation state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sat_q   <= '0;
      vxsat_q <= 1'b0;
    end else begin
      sat_q   <= sat_d;
      vxsat_q <= vxsat_d;
    end
  end

  assign vxsat_o = vxsat_q;
`else
  logic unused_vxsat_clr;
  assign unused_vxsat_clr = vxsat_clr_i;
  assign vxsat_o          = 1'b0;
`endif

endmodule

// File: tb/tb_vpu_alu_simd.sv
// Directed self-checking bench for vpu_alu_simd (DATA_W=64, LATENCY=2).
// Expectations follow VPU_ALU_VXSAT_EN when the macro is defined for the build.
module tb_vpu_alu_simd;
  localparam int DATA_W  = 64;
  localparam int LATENCY = 2;
  localparam int NB      = DATA_W / 8;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [3:0]        op_i;
  logic              signed_i;
  logic [1:0]        sew_i;
  logic [DATA_W-1:0] op1_i, op2_i;
  logic [NB-1:0]     mask_i;
  logic              flush_i;
  logic              vxsat_clr_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] result_o;
  logic [NB-1:0]     be_o;
  logic              vxsat_o;

  int vectors     = 0;
  int miscompares = 0;

  vpu_alu_simd #(.DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .signed_i(signed_i), .sew_i(sew_i), .op1_i(op1_i), .op2_i(op2_i),
    .mask_i(mask_i), .flush_i(flush_i), .vxsat_clr_i(vxsat_clr_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
    .be_o(be_o), .vxsat_o(vxsat_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive one beat into an idle pipeline; return result, byte enables and latency.
  task automatic run_beat(input logic [3:0] op, input logic sgn, input logic [1:0] sew,
                          input logic [63:0] a1, input logic [63:0] a2, input logic [7:0] m,
                          output logic [63:0] res, output logic [7:0] be, output int lat);
    op_i = op; signed_i = sgn; sew_i = sew; op1_i = a1; op2_i = a2; mask_i = m;
    out_ready_i = 1'b1; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 20) begin
      @(posedge clk_i); #1;
      lat++;
    end
    res = result_o;
    be  = be_o;
    @(posedge clk_i); #1;
  endtask

  task automatic clear_vxsat();
    vxsat_clr_i = 1'b1;
    @(posedge clk_i); #1;
    vxsat_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    vectors += 5;
    if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", out_valid_o); end
    if (result_o !== '0)      begin miscompares++; $display("FAIL reset_result: got %h expected 0", result_o); end
    if (be_o !== '0)          begin miscompares++; $display("FAIL reset_be: got %h expected 0", be_o); end
    if (vxsat_o !== 1'b0)     begin miscompares++; $display("FAIL reset_vxsat: got %b expected 0", vxsat_o); end
    if (in_ready_o !== 1'b1)  begin miscompares++; $display("FAIL reset_ready: got %b expected 1", in_ready_o); end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_add();
    logic [63:0] r; logic [7:0] b; int lat;
    run_beat(4'd0, 1'b0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0807_0605_0403_0201, 8'hFF, r, b, lat);
    vectors += 3;
    if (r !== 64'h0706_0504_0302_0100) begin miscompares++; $display("FAIL add8_result: got %h expected 0706050403020100", r); end
    if (b !== 8'hFF) begin miscompares++; $display("FAIL add8_be: got %h expected ff", b); end
    if (lat != LATENCY) begin miscompares++; $display("FAIL add8_latency: got %0d expected %0d", lat, LATENCY); end
  endtask

  task automatic test_sadd();
    logic [63:0] r, exp_r; logic [7:0] b; int lat; logic exp_sat;
`ifdef VPU_ALU_VXSAT_EN
    exp_r = 64'h0000_7FFF_0000_7FFF; exp_sat = 1'b1;
`else
    exp_r = 64'h0000_8010_0000_8010; exp_sat = 1'b0;
`endif
    clear_vxsat();
    run_beat(4'd14, 1'b1, 2'd1, 64'h0020_0020_0020_0020, 64'h7FF0_7FF0_7FF0_7FF0, 8'h05, r, b, lat);
    vectors += 3;
    if (r !== exp_r) begin miscompares++; $display("FAIL sadd16_result: got %h expected %h", r, exp_r); end
    if (b !== 8'h33) begin miscompares++; $display("FAIL sadd16_be: got %h expected 33", b); end
    if (vxsat_o !== exp_sat) begin miscompares++; $display("FAIL sadd16_vxsat: got %b expected %b", vxsat_o, exp_sat); end
  endtask

  task automatic test_mslt();
    logic [63:0] r; logic [7:0] b; int lat;
    run_beat(4'd13, 1'b1, 2'd2, 64'h0000_0001_0000_0003, 64'hFFFF_FFFF_0000_0005, 8'hFF, r, b, lat);
    vectors += 2;
    if (r !== 64'h2)  begin miscompares++; $display("FAIL mslt_signed: got %h expected 2", r); end
    if (b !== 8'hFF)  begin miscompares++; $display("FAIL mslt_be: got %h expected ff", b); end
    run_beat(4'd13, 1'b0, 2'd2, 64'h0000_0001_0000_0003, 64'hFFFF_FFFF_0000_0005, 8'hFF, r, b, lat);
    vectors += 1;
    if (r !== 64'h0)  begin miscompares++; $display("FAIL mslt_unsigned: got %h expected 0", r); end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic        sgn;
    logic [1:0]  sew;
    logic [63:0] a1, a2;
    logic [7:0]  m;
    logic [63:0] er;
    logic [7:0]  eb;
  } vec_t;

  task automatic test_ops();
    vec_t tv [13];
    logic [63:0] r; logic [7:0] b; int lat;
    tv[0]  = '{4'd1,  1'b0, 2'd0, 64'h0101_0101_0101_0101, 64'h0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF};
    tv[1]  = '{4'd8,  1'b0, 2'd1, 64'h0014_0014_0014_0014, 64'h8000_8000_8000_8000, 8'h0F, 64'hF800_F800_F800_F800, 8'hFF};
    tv[2]  = '{4'd9,  1'b1, 2'd2, 64'h0000_0001_0000_0009, 64'hFFFF_FFFF_0000_0007, 8'h03, 64'hFFFF_FFFF_0000_0007, 8'hFF};
    tv[3]  = '{4'd10, 1'b0, 2'd2, 64'h0000_0001_0000_0009, 64'hFFFF_FFFF_0000_0007, 8'h03, 64'hFFFF_FFFF_0000_0009, 8'hFF};
    tv[4]  = '{4'd2,  1'b0, 2'd3, 64'h5, 64'h3, 8'h01, 64'h2, 8'hFF};
    tv[5]  = '{4'd11, 1'b0, 2'd0, 64'h1122_0044_5500_7788, 64'h1122_3344_5566_7788, 8'hFE, 64'hDA, 8'hFF};
    tv[6]  = '{4'd5,  1'b0, 2'd0, 64'h0F0F_0F0F_0F0F_0F0F, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0000_0000_F0F0_F0F0, 8'h0F};
    tv[7]  = '{4'd6,  1'b0, 2'd1, 64'h000F_000F_000F_000F, 64'h0001_0001_0001_0001, 8'h0F, 64'h8000_8000_8000_8000, 8'hFF};
    tv[8]  = '{4'd7,  1'b0, 2'd2, 64'h0000_0021_0000_001F, 64'h8000_0000_8000_0000, 8'h03, 64'h4000_0000_0000_0001, 8'hFF};
    tv[9]  = '{4'd12, 1'b0, 2'd1, 64'h0001_0002_0003_0004, 64'h0001_0000_0003_0000, 8'h07, 64'h5, 8'hFF};
    tv[10] = '{4'd3,  1'b0, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 8'h00, 64'h0, 8'h00};
    tv[11] = '{4'd11, 1'b0, 2'd3, 64'hAAAA, 64'hAAAA, 8'hFF, 64'h1, 8'hFF};
    tv[12] = '{4'd4,  1'b0, 2'd3, 64'hF0, 64'h0F, 8'h01, 64'hFF, 8'hFF};
    for (int i = 0; i < 13; i++) begin
      run_beat(tv[i].op, tv[i].sgn, tv[i].sew, tv[i].a1, tv[i].a2, tv[i].m, r, b, lat);
      vectors += 2;
      if (r !== tv[i].er) begin miscompares++; $display("FAIL op_vec%0d_result: got %h expected %h", i, r, tv[i].er); end
      if (b !== tv[i].eb) begin miscompares++; $display("FAIL op_vec%0d_be: got %h expected %h", i, b, tv[i].eb); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] bo1 [4], bo2 [4], bexp [4];
    logic [1:0]  bsew [4];
    logic [63:0] prev_res;
    logic        prev_stall, acc;
    int sent, recv;
    bsew[0] = 2'd3; bo2[0] = 64'hFFFF_FFFF; bo1[0] = 64'h1; bexp[0] = 64'h1_0000_0000;
    bsew[1] = 2'd0; bo2[1] = 64'h01FF;      bo1[1] = 64'h1; bexp[1] = 64'h0100;
    bsew[2] = 2'd1; bo2[2] = 64'h00FF;      bo1[2] = 64'h1; bexp[2] = 64'h0100;
    bsew[3] = 2'd2; bo2[3] = 64'h0000_FFFF; bo1[3] = 64'h1; bexp[3] = 64'h0001_0000;
    sent = 0; recv = 0; prev_stall = 1'b0; prev_res = '0;
    op_i = 4'd0; signed_i = 1'b0; mask_i = 8'hFF;
    for (int c = 0; c < 40 && recv < 4; c++) begin
      out_ready_i = !(c >= 3 && c < 6);
      if (sent < 4) begin
        in_valid_i = 1'b1; sew_i = bsew[sent]; op1_i = bo1[sent]; op2_i = bo2[sent];
      end else begin
        in_valid_i = 1'b0;
      end
      #1;
      if (prev_stall) begin
        vectors++;
        if (out_valid_o !== 1'b1 || result_o !== prev_res) begin
          miscompares++;
          $display("FAIL b2b_stall_hold: got valid=%b result=%h expected valid=1 result=%h", out_valid_o, result_o, prev_res);
        end
      end
      acc = in_valid_i && in_ready_o;
      if (out_valid_o && out_ready_i) begin
        vectors++;
        if (recv >= 4) begin
          miscompares++; $display("FAIL b2b_extra_beat: got %h expected no beat", result_o);
        end else if (result_o !== bexp[recv]) begin
          miscompares++; $display("FAIL b2b_beat%0d: got %h expected %h", recv, result_o, bexp[recv]);
        end
        recv++;
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_res   = result_o;
      @(posedge clk_i); #1;
      if (acc) sent++;
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    vectors++;
    if (recv != 4 || sent != 4) begin
      miscompares++; $display("FAIL b2b_count: got sent=%0d recv=%0d expected 4 and 4", sent, recv);
    end
    repeat (2) @(posedge clk_i);
    #1;
    vectors++;
    if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL b2b_drained: got %b expected 0", out_valid_o); end
  endtask

  task automatic test_flush();
    logic [63:0] r; logic [7:0] b; int lat; int seen;
    clear_vxsat();
    op_i = 4'd14; signed_i = 1'b1; sew_i = 2'd1; mask_i = 8'hFF;
    op1_i = 64'h0020_0020_0020_0020; op2_i = 64'h7FF0_7FF0_7FF0_7FF0;
    out_ready_i = 1'b1; in_valid_i = 1'b1;
    repeat (2) begin @(posedge clk_i); #1; end
    out_ready_i = 1'b0; flush_i = 1'b1;
    #1;
    vectors += 2;
    if (in_ready_o !== 1'b0)  begin miscompares++; $display("FAIL flush_ready: got %b expected 0", in_ready_o); end
    if (out_valid_o !== 1'b1) begin miscompares++; $display("FAIL flush_full: got %b expected 1", out_valid_o); end
    @(posedge clk_i); #1;
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    vectors++;
    if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b expected 0", out_valid_o); end
    seen = 0;
    repeat (4) begin
      @(posedge clk_i); #1;
      if (out_valid_o) seen++;
    end
    vectors += 2;
    if (seen != 0)        begin miscompares++; $display("FAIL flush_ghost: got %0d beats expected 0", seen); end
    if (vxsat_o !== 1'b0) begin miscompares++; $display("FAIL flush_vxsat: got %b expected 0", vxsat_o); end
    run_beat(4'd0, 1'b0, 2'd3, 64'h1, 64'h2, 8'h01, r, b, lat);
    vectors += 2;
    if (r !== 64'h3)    begin miscompares++; $display("FAIL flush_next_result: got %h expected 3", r); end
    if (lat != LATENCY) begin miscompares++; $display("FAIL flush_next_latency: got %0d expected %0d", lat, LATENCY); end
  endtask

  task automatic test_vxsat_clear();
    logic [63:0] exp_r; logic exp_sat; int wait_cnt;
`ifdef VPU_ALU_VXSAT_EN
    exp_r = 64'h0; exp_sat = 1'b1;
`else
    exp_r = 64'hFFFF_FFFF_FFFF_FFFE; exp_sat = 1'b0;
`endif
    clear_vxsat();
    op_i = 4'd15; signed_i = 1'b0; sew_i = 2'd3; op1_i = 64'h5; op2_i = 64'h3; mask_i = 8'h01;
    out_ready_i = 1'b1; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    wait_cnt = 0;
    while (!out_valid_o && wait_cnt < 20) begin
      @(posedge clk_i); #1;
      wait_cnt++;
    end
    vectors++;
    if (out_valid_o !== 1'b1 || result_o !== exp_r) begin
      miscompares++; $display("FAIL ssub64_result: got valid=%b %h expected valid=1 %h", out_valid_o, result_o, exp_r);
    end
    vxsat_clr_i = 1'b1;
    @(posedge clk_i); #1;
    vectors++;
    if (vxsat_o !== exp_sat) begin miscompares++; $display("FAIL vxsat_set_wins: got %b expected %b", vxsat_o, exp_sat); end
    @(posedge clk_i); #1;
    vxsat_clr_i = 1'b0;
    vectors++;
    if (vxsat_o !== 1'b0) begin miscompares++; $display("FAIL vxsat_clear: got %b expected 0", vxsat_o); end
  endtask

  task automatic test_reset_mid();
    int seen;
    op_i = 4'd0; sew_i = 2'd3; op1_i = 64'h1; op2_i = 64'h1; mask_i = 8'hFF;
    out_ready_i = 1'b1; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    rst_ni = 1'b0;
    #2;
    vectors++;
    if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %b expected 0", out_valid_o); end
    rst_ni = 1'b1;
    seen = 0;
    repeat (4) begin
      @(posedge clk_i); #1;
      if (out_valid_o) seen++;
    end
    vectors++;
    if (seen != 0) begin miscompares++; $display("FAIL rstmid_ghost: got %0d beats expected 0", seen); end
  endtask

  initial begin
    rst_ni = 1'b0; in_valid_i = 1'b0; op_i = '0; signed_i = 1'b0; sew_i = '0;
    op1_i = '0; op2_i = '0; mask_i = '0; flush_i = 1'b0; vxsat_clr_i = 1'b0;
    out_ready_i = 1'b0;
    test_reset();
    test_add();
    test_sadd();
    test_mslt();
    test_ops();
    test_back_to_back();
    test_flush();
    test_vxsat_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
